// File: rtl/mixer_gain_sequencer.sv
// Four-channel mixer gain sequencer: on each codec frame, every gain steps toward its
// commanded target, one channel per clock, with no wrap and no overshoot.
module mixer_gain_sequencer #(
    parameter int BITSIZE = 24
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               lrclk,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_chan,
    input  logic [BITSIZE-1:0] cmd_gain,
    input  logic [BITSIZE-1:0] cmd_step,
    output logic [BITSIZE-1:0] n1,
    output logic [BITSIZE-1:0] n2,
    output logic [BITSIZE-1:0] n3,
    output logic [BITSIZE-1:0] n4,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
);
    localparam int CHANNELS = 4;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         chanIdx_q, chanIdx_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic               lrSync1_q, lrSync2_q, lrPrev_q;
    logic [BITSIZE-1:0] gain_q   [CHANNELS];
    logic [BITSIZE-1:0] gain_d   [CHANNELS];
    logic [BITSIZE-1:0] target_q [CHANNELS];
    logic [BITSIZE-1:0] target_d [CHANNELS];
    logic [BITSIZE-1:0] step_q   [CHANNELS];
    logic [BITSIZE-1:0] step_d   [CHANNELS];

    logic               tick;
    logic               handshake;
    logic [BITSIZE-1:0] curGain, curTarget, curStep, distance, rampGain;

    assign tick       = lrPrev_q & ~lrSync2_q;
    // Gated by resetn so the block never advertises readiness while held in reset.
    assign cmd_ready  = resetn & (state_q == IDLE);
    assign handshake  = cmd_valid & cmd_ready;
    assign frame_done = (state_q == DONE);
    assign overrun    = overrun_q;
    assign n1         = gain_q[0];
    assign n2         = gain_q[1];
    assign n3         = gain_q[2];
    assign n4         = gain_q[3];

    // The subtraction is only taken when the distance exceeds the step, so it cannot wrap.
    always_comb begin
        curGain   = gain_q[chanIdx_q];
        curTarget = target_q[chanIdx_q];
        curStep   = step_q[chanIdx_q];
        distance  = (curTarget >= curGain) ? (curTarget - curGain) : (curGain - curTarget);
        if ((curStep == '0) || (distance <= curStep)) begin
            rampGain = curTarget;
        end else if (curTarget > curGain) begin
            rampGain = curGain + curStep;
        end else begin
            rampGain = curGain - curStep;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy = busy | (gain_q[i] != target_q[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        chanIdx_d = chanIdx_q;
        pending_d = pending_q;
        overrun_d = overrun_q | (tick & pending_q);
        gain_d    = gain_q;
        target_d  = target_q;
        step_d    = step_q;

        if (handshake) begin
            target_d[cmd_chan] = cmd_gain;
            step_d[cmd_chan]   = cmd_step;
        end

        case (state_q)
            IDLE: begin
                if (tick || pending_q) begin
                    state_d   = SWEEP;
                    chanIdx_d = 2'd0;
                    pending_d = 1'b0;
                end
            end
            SWEEP: begin
                gain_d[chanIdx_q] = rampGain;
                chanIdx_d         = chanIdx_q + 2'd1;
                if (chanIdx_q == 2'd3) begin
                    state_d = DONE;
                end
                if (tick) begin
                    pending_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (tick) begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            chanIdx_q <= 2'd0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            lrSync1_q <= 1'b1;
            lrSync2_q <= 1'b1;
            lrPrev_q  <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                gain_q[i]   <= '0;
                target_q[i] <= '0;
                step_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            chanIdx_q <= chanIdx_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            lrSync1_q <= lrclk;
            lrSync2_q <= lrSync1_q;
            lrPrev_q  <= lrSync2_q;
            gain_q    <= gain_d;
            target_q  <= target_d;
            step_q    <= step_d;
        end
    end
endmodule

// File: tb/tb_mixer_gain_sequencer.sv
// Bench for mixer_gain_sequencer: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a frame-level behavioural model.
module tb_mixer_gain_sequencer;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         lrclk = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_chan = 2'd0;
    logic [W-1:0] cmd_gain = '0;
    logic [W-1:0] cmd_step = '0;
    logic [W-1:0] n1, n2, n3, n4;
    logic         busy, frame_done, overrun;

    int checks = 0;
    int errors = 0;
    int fdCount = 0;
    int dutHs = 0;
    bit checkEn = 1'b0;

    logic [W-1:0] mGain [4];
    logic [W-1:0] mTgt  [4];
    logic [W-1:0] mStep [4];
    int           phase;
    bit           mPending, mOverrun;
    bit           hSync1, hSync2, hPrev;

    mixer_gain_sequencer #(.BITSIZE(W)) dut (
        .clk(clk), .resetn(resetn), .lrclk(lrclk),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan),
        .cmd_gain(cmd_gain), .cmd_step(cmd_step),
        .n1(n1), .n2(n2), .n3(n3), .n4(n4),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rampModel(input logic [W-1:0] g, input logic [W-1:0] t,
                                               input logic [W-1:0] s);
        longint gi, ti, si, d, ad;
        gi = longint'(g);
        ti = longint'(t);
        si = longint'(s);
        d  = ti - gi;
        ad = (d < 0) ? -d : d;
        if (si == 0 || ad <= si) return t;
        if (d > 0) return W'(gi + si);
        return W'(gi - si);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // phase: -1 waiting for a frame, 0..3 channel being ramped, 4 end-of-frame pulse.
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                mGain[i] = '0;
                mTgt[i]  = '0;
                mStep[i] = '0;
            end
            phase    = -1;
            mPending = 1'b0;
            mOverrun = 1'b0;
            hSync1   = 1'b1;
            hSync2   = 1'b1;
            hPrev    = 1'b1;
        end else begin
            bit frameTick;
            bit accept;
            frameTick = hPrev && !hSync2;
            accept    = cmd_valid && (phase < 0);
            if (frameTick && mPending) mOverrun = 1'b1;
            if (phase < 0) begin
                if (frameTick || mPending) begin
                    phase    = 0;
                    mPending = 1'b0;
                end
            end else begin
                if (frameTick) mPending = 1'b1;
                if (phase <= 3) begin
                    mGain[phase] = rampModel(mGain[phase], mTgt[phase], mStep[phase]);
                    phase++;
                end else begin
                    phase = -1;
                end
            end
            if (accept) begin
                mTgt[cmd_chan]  = cmd_gain;
                mStep[cmd_chan] = cmd_step;
            end
            hPrev  = hSync2;
            hSync2 = hSync1;
            hSync1 = lrclk;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            bit mBusy;
            mBusy = 1'b0;
            for (int i = 0; i < 4; i++) mBusy = mBusy | (mGain[i] != mTgt[i]);
            checkOutput("n1", 32'(n1), 32'(mGain[0]));
            checkOutput("n2", 32'(n2), 32'(mGain[1]));
            checkOutput("n3", 32'(n3), 32'(mGain[2]));
            checkOutput("n4", 32'(n4), 32'(mGain[3]));
            checkOutput("busy", 32'(busy), 32'(mBusy));
            checkOutput("frame_done", 32'(frame_done), 32'(phase == 4));
            checkOutput("overrun", 32'(overrun), 32'(mOverrun));
            checkOutput("cmd_ready", 32'(cmd_ready), 32'(resetn && phase < 0));
            if (frame_done === 1'b1) fdCount++;
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) dutHs++;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit valid, input logic [1:0] chan,
                                 input logic [W-1:0] gain, input logic [W-1:0] step);
        cmd_valid = valid;
        cmd_chan  = chan;
        cmd_gain  = gain;
        cmd_step  = step;
    endtask

    task automatic sendCommand(input logic [1:0] chan, input logic [W-1:0] gain,
                               input logic [W-1:0] step);
        int waited;
        applyStimulus(1'b1, chan, gain, step);
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) checkOutput("cmdReadyTimeout", 32'(cmd_ready), 32'd1);
        nextCycle();
        cmd_valid = 1'b0;
    endtask

    task automatic runFrame();
        int waited;
        lrclk = 1'b0;
        nextCycle();
        lrclk = 1'b1;
        waited = 0;
        while (frame_done !== 1'b1 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        if (frame_done !== 1'b1) checkOutput("frameTimeout", 32'(frame_done), 32'd1);
        nextCycle();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fdStart, hsStart, waited;

        resetn = 1'b0;
        nextCycle();
        checkEn = 1'b1;
        nextCycle();
        checkOutput("resetN1", 32'(n1), 32'd0);
        checkOutput("resetN4", 32'(n4), 32'd0);
        checkOutput("resetReadyLow", 32'(cmd_ready), 32'd0);
        checkOutput("resetOverrun", 32'(overrun), 32'd0);
        resetn = 1'b1;
        #1;
        checkOutput("readyAfterRelease", 32'(cmd_ready), 32'd1);
        nextCycle();

        // Jump on channel 1.
        sendCommand(2'd1, 24'h100000, 24'h0);
        fdStart = fdCount;
        runFrame();
        checkOutput("jumpN2", 32'(n2), 32'h100000);
        checkOutput("jumpN1", 32'(n1), 32'h0);
        checkOutput("jumpN3", 32'(n3), 32'h0);
        checkOutput("jumpFrames", 32'(fdCount - fdStart), 32'd1);
        checkOutput("jumpBusy", 32'(busy), 32'd0);

        // Ramp up on channel 0.
        sendCommand(2'd0, 24'h000100, 24'h000040);
        for (int k = 1; k <= 5; k++) begin
            runFrame();
            checkOutput("rampN1", 32'(n1), (k < 4) ? 32'(k * 'h40) : 32'h100);
            if (k == 3) checkOutput("rampBusy3", 32'(busy), 32'd1);
            if (k == 4) checkOutput("rampBusy4", 32'(busy), 32'd0);
        end

        // Clamp down on channel 2.
        sendCommand(2'd2, 24'h000100, 24'h0);
        runFrame();
        checkOutput("clampPre", 32'(n3), 32'h100);
        sendCommand(2'd2, 24'h0000F0, 24'h000040);
        runFrame();
        checkOutput("clampN3", 32'(n3), 32'hF0);

        // Command held while a sweep runs.
        lrclk = 1'b0;
        nextCycle();
        lrclk = 1'b1;
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 2'd3, 24'h000055, 24'h0);
        hsStart = dutHs;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        nextCycle();
        cmd_valid = 1'b0;
        repeat (3) nextCycle();
        checkOutput("contentionWaited", 32'(waited > 0), 32'd1);
        checkOutput("contentionAccepts", 32'(dutHs - hsStart), 32'd1);
        runFrame();
        checkOutput("contentionN4", 32'(n4), 32'h55);

        // Three frame edges in quick succession: two land inside the same sweep.
        fdStart = fdCount;
        for (int k = 0; k < 3; k++) begin
            lrclk = 1'b0;
            nextCycle();
            lrclk = 1'b1;
            nextCycle();
        end
        repeat (20) nextCycle();
        checkOutput("overrunFrames", 32'(fdCount - fdStart), 32'd2);
        checkOutput("overrunSet", 32'(overrun), 32'd1);
        runFrame();
        checkOutput("overrunSticky", 32'(overrun), 32'd1);

        // Reset in the middle of a sweep.
        sendCommand(2'd0, 24'h001000, 24'h000010);
        lrclk = 1'b0;
        nextCycle();
        lrclk = 1'b1;
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("midSweepN1", 32'(n1), 32'h110);
        resetn = 1'b0;
        nextCycle();
        checkOutput("abortN1", 32'(n1), 32'h0);
        checkOutput("abortN2", 32'(n2), 32'h0);
        checkOutput("abortN4", 32'(n4), 32'h0);
        checkOutput("abortOverrun", 32'(overrun), 32'd0);
        checkOutput("abortReady", 32'(cmd_ready), 32'd0);
        resetn = 1'b1;
        #1;
        checkOutput("abortReadyRelease", 32'(cmd_ready), 32'd1);
        nextCycle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [W-1:0] g, s;
            g = W'($urandom);
            if ($urandom_range(0, 1) == 0) g = W'($urandom_range(0, 'h3FF));
            case ($urandom_range(0, 3))
                0: s = '0;
                1: s = W'($urandom_range(1, 'h40));
                2: s = W'($urandom);
                default: s = W'($urandom_range(1, 'hFFFF));
            endcase
            applyStimulus($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), g, s);
            if ($urandom_range(0, 2) == 0) lrclk = ~lrclk;
            resetn = ($urandom_range(0, 299) != 0);
            nextCycle();
        end
        applyStimulus(1'b0, 2'd0, '0, '0);
        resetn = 1'b1;
        lrclk = 1'b1;
        repeat (20) nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
